// File: rtl/axi_rd_master_if.sv
// Client command/beat port plus AXI3 AR/R channels of the read initiator.
// master modport is the initiator's view; slave modport is the environment's view.
interface axi_rd_master_if #(
  parameter int unsigned aw  = 12,
  parameter int unsigned dw  = 32,
  parameter int unsigned idw = 16
);
  // client command
  logic           cmd_valid;
  logic           cmd_ready;
  logic [aw-1:0]  cmd_addr;
  logic [3:0]     cmd_len;
  logic [idw-1:0] cmd_id;
  // client beat stream
  logic           rd_valid;
  logic           rd_ready;
  logic [dw-1:0]  rd_data;
  logic           rd_last;
  logic [1:0]     rd_resp;
  // AXI AR
  logic           arvalid;
  logic           arready;
  logic [aw-1:0]  araddr;
  logic [1:0]     arburst;
  logic [2:0]     arsize;
  logic [3:0]     arlen;
  logic [idw-1:0] arid;
  // AXI R
  logic           rvalid;
  logic           rready;
  logic [idw-1:0] rid;
  logic [dw-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_id, rd_ready,
           arready, rvalid, rid, rdata, rresp, rlast,
    output cmd_ready, rd_valid, rd_data, rd_last, rd_resp,
           arvalid, araddr, arburst, arsize, arlen, arid, rready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_id, rd_ready,
           arready, rvalid, rid, rdata, rresp, rlast,
    input  cmd_ready, rd_valid, rd_data, rd_last, rd_resp,
           arvalid, araddr, arburst, arsize, arlen, arid, rready
  );
endinterface

// File: rtl/axi_rd_master.sv
// AXI3 read initiator: one outstanding INCR burst, R-channel protocol checking.
// Optional AXI_RD_MASTER_TIMEOUT_EN adds a stall timeout with sticky timeout_err.
module axi_rd_master #(
  parameter int unsigned aw  = 12,
  parameter int unsigned dw  = 32,
  parameter int unsigned idw = 16
`ifdef AXI_RD_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TO_CYCLES = 256
`endif
) (
  input  logic              aclk,
  input  logic              areset,
  axi_rd_master_if.master   bus,
  output logic              busy,
  output logic              prot_err
`ifdef AXI_RD_MASTER_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam int unsigned SizeLog2 = $clog2(dw / 8);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e         state_q;
  logic           cmd_ready_q;
  logic           arvalid_q;
  logic [aw-1:0]  araddr_q;
  logic [3:0]     arlen_q;
  logic [idw-1:0] arid_q;
  logic [3:0]     beat_cnt_q;
  logic           busy_q;
  logic           prot_err_q;

  logic in_data_c;
  logic ar_hs_c;
  logic r_hs_c;
  logic at_len_c;
  logic r_err_c;

  assign in_data_c = (state_q == DATA);
  assign ar_hs_c   = (state_q == ADDR) && arvalid_q && bus.arready;
  assign r_hs_c    = in_data_c && bus.rvalid && bus.rd_ready;
  assign at_len_c  = (beat_cnt_q == arlen_q);
  // rlast must coincide exactly with the counted last beat
  assign r_err_c   = (bus.rid != arid_q) || (bus.rlast != at_len_c);

`ifdef AXI_RD_MASTER_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic [15:0] to_cnt_d;
  logic        timeout_err_q;

  assign to_cnt_d    = to_cnt_q + 16'd1;
  assign timeout_err = timeout_err_q;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arid_q      <= '0;
      beat_cnt_q  <= '0;
      busy_q      <= 1'b0;
      prot_err_q  <= 1'b0;
`ifdef AXI_RD_MASTER_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            araddr_q    <= bus.cmd_addr;
            arlen_q     <= bus.cmd_len;
            arid_q      <= bus.cmd_id;
            beat_cnt_q  <= '0;
            arvalid_q   <= 1'b1;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs_c) begin
            arvalid_q <= 1'b0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (r_hs_c) begin
            if (r_err_c) prot_err_q <= 1'b1;
            if (beat_cnt_q != 4'hF) beat_cnt_q <= beat_cnt_q + 4'd1;
            if (at_len_c) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          arvalid_q   <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
`ifdef AXI_RD_MASTER_TIMEOUT_EN
      // stall counter; expiry abandons the burst and overrides the case above
      if (state_q == IDLE || ar_hs_c || r_hs_c) begin
        to_cnt_q <= '0;
      end else if (to_cnt_d == 16'(TO_CYCLES)) begin
        to_cnt_q      <= to_cnt_d;
        timeout_err_q <= 1'b1;
        state_q       <= IDLE;
        arvalid_q     <= 1'b0;
        busy_q        <= 1'b0;
        cmd_ready_q   <= 1'b1;
      end else begin
        to_cnt_q <= to_cnt_d;
      end
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.arvalid   = arvalid_q;
  assign bus.araddr    = araddr_q;
  assign bus.arlen     = arlen_q;
  assign bus.arid      = arid_q;
  assign bus.arburst   = 2'b01;
  assign bus.arsize    = 3'(SizeLog2);

  // R channel is a straight pass-through to the client while in DATA
  assign bus.rready    = in_data_c && bus.rd_ready;
  assign bus.rd_valid  = in_data_c && bus.rvalid;
  assign bus.rd_data   = in_data_c ? bus.rdata : '0;
  assign bus.rd_resp   = in_data_c ? bus.rresp : 2'b00;
  assign bus.rd_last   = in_data_c && at_len_c;

  assign busy     = busy_q;
  assign prot_err = prot_err_q;

endmodule

// File: tb/tb_axi_rd_master.sv
// Randomized self-checking bench for axi_rd_master; acts as AXI slave and client.
module tb_axi_rd_master;
  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned IDW = 16;

  logic aclk = 1'b0;
  logic areset;
  logic busy;
  logic prot_err;
`ifdef AXI_RD_MASTER_TIMEOUT_EN
  logic timeout_err;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          exp_perr = 1'b0;

  axi_rd_master_if #(.aw(AW), .dw(DW), .idw(IDW)) bus ();

  axi_rd_master #(.aw(AW), .dw(DW), .idw(IDW)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .bus      (bus.master),
    .busy     (busy),
    .prot_err (prot_err)
`ifdef AXI_RD_MASTER_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_id    = '0;
    bus.rd_ready  = 1'b0;
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rid       = '0;
    bus.rdata     = '0;
    bus.rresp     = 2'b00;
    bus.rlast     = 1'b0;
  endtask

  // Called at a negedge: reset for one edge with busy-looking inputs, then check reset state.
  task automatic reset_and_check();
    areset       = 1'b1;
    bus.rvalid   = 1'b1;
    bus.rd_ready = 1'b1;
    bus.rlast    = 1'b1;
    bus.rdata    = 32'hFFFF_FFFF;
    bus.rresp    = 2'd3;
    bus.arready  = 1'b1;
    @(negedge aclk);
    check("rst_arvalid",  64'(bus.arvalid),  64'(0));
    check("rst_rready",   64'(bus.rready),   64'(0));
    check("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
    check("rst_rd_last",  64'(bus.rd_last),  64'(0));
    check("rst_busy",     64'(busy),         64'(0));
    check("rst_prot_err", 64'(prot_err),     64'(0));
    check("rst_araddr",   64'(bus.araddr),   64'(0));
    check("rst_arlen",    64'(bus.arlen),    64'(0));
    check("rst_arid",     64'(bus.arid),     64'(0));
    check("rst_rd_data",  64'(bus.rd_data),  64'(0));
    check("rst_rd_resp",  64'(bus.rd_resp),  64'(0));
    check("rst_cmd_ready",64'(bus.cmd_ready),64'(1));
    exp_perr = 1'b0;
    areset   = 1'b0;
    drive_idle();
  endtask

  // One command + burst. rid_bad/rst_beat = -1 disables; rlast_beat = len for a clean burst.
  // rdy_mode: 0 always ready, 1 toggling, 2 random.
  task automatic do_burst(input logic [AW-1:0] addr, input logic [3:0] len, input logic [IDW-1:0] id,
                          input logic [DW-1:0] d0, input int rid_bad, input int rlast_beat,
                          input int ar_delay, input int rdy_mode, input int rst_beat);
    logic [DW-1:0] dat [16];
    logic [1:0]    rsp [16];
    int beat;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      dat[i] = DW'($urandom);
      rsp[i] = 2'($urandom_range(0, 3));
    end
    dat[0] = d0;

    check("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("idle_busy",      64'(busy),          64'(0));
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_id    = id;
    @(negedge aclk);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = ~addr;
    bus.cmd_len   = ~len;
    bus.cmd_id    = ~id;

    // address phase, possibly stalled
    for (int d = 0; d <= ar_delay; d++) begin
      bus.arready = (d == ar_delay);
      #1;
      check("arvalid",   64'(bus.arvalid),   64'(1));
      check("busy",      64'(busy),          64'(1));
      check("cmd_ready", 64'(bus.cmd_ready), 64'(0));
      check("araddr",    64'(bus.araddr),    64'(addr));
      check("arlen",     64'(bus.arlen),     64'(len));
      check("arid",      64'(bus.arid),      64'(id));
      check("arsize",    64'(bus.arsize),    64'(2));
      check("arburst",   64'(bus.arburst),   64'(1));
      @(negedge aclk);
    end
    bus.arready = 1'b0;

    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 400) begin
      bit v;
      bit rdy;
      v = ($urandom_range(0, 3) != 0);
      if (rdy_mode == 0)      rdy = 1'b1;
      else if (rdy_mode == 1) rdy = ((cyc % 2) == 0);
      else                    rdy = 1'($urandom_range(0, 1));
      if (beat == rst_beat && v) begin
        reset_and_check();
        return;
      end
      bus.rvalid   = v;
      bus.rd_ready = rdy;
      bus.rid      = (beat == rid_bad) ? id + 16'd1 : id;
      bus.rdata    = dat[beat];
      bus.rresp    = rsp[beat];
      bus.rlast    = (beat == rlast_beat);
      #1;
      check("rready",   64'(bus.rready),   64'(rdy));
      check("rd_valid", 64'(bus.rd_valid), 64'(v));
      check("arvalid_data", 64'(bus.arvalid), 64'(0));
      if (v) begin
        check("rd_data", 64'(bus.rd_data), 64'(dat[beat]));
        check("rd_resp", 64'(bus.rresp == bus.rd_resp), 64'(1));
        check("rd_last", 64'(bus.rd_last), 64'(beat == int'(len)));
      end
      if (v && rdy) begin
        // a beat is bad if its ID is wrong or rlast disagrees with being the final beat
        if (beat == rid_bad || ((beat == rlast_beat) != (beat == int'(len))))
          exp_perr = 1'b1;
        beat++;
      end
      cyc++;
      @(negedge aclk);
    end
    if (cyc >= 400) check("burst_bound", 64'(1), 64'(0));

    bus.rvalid   = 1'b0;
    bus.rd_ready = 1'b0;
    bus.rlast    = 1'b0;
    #1;
    check("done_busy",      64'(busy),          64'(0));
    check("done_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("done_rd_valid",  64'(bus.rd_valid),  64'(0));
    check("prot_err",       64'(prot_err),      64'(exp_perr));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    drive_idle();
    @(negedge aclk);
    reset_and_check();

    // single beat, immediate arready
    do_burst(12'h100, 4'd0, 16'h5, 32'hDEAD_BEEF, -1, 0, 0, 0, -1);
    // 16 beats, toggling client ready, AR stalled 3 cycles
    do_burst(12'h200, 4'd15, 16'h1234, 32'($urandom), -1, 15, 3, 1, -1);
    // rlast on beat 2 of 4, then a clean burst keeps the sticky error
    do_burst(12'h040, 4'd3, 16'h22, 32'($urandom), -1, 1, 1, 2, -1);
    do_burst(12'h080, 4'd2, 16'h23, 32'($urandom), -1, 2, 0, 0, -1);
    // wrong rid
    reset_and_check();
    do_burst(12'h300, 4'd0, 16'h5, 32'hCAFE_F00D, 0, 0, 0, 0, -1);
    // reset during beat 2 of 8, then a clean command
    reset_and_check();
    do_burst(12'h400, 4'd7, 16'h9, 32'($urandom), -1, 7, 0, 0, 1);
    do_burst(12'h410, 4'd5, 16'hA, 32'($urandom), -1, 5, 2, 2, -1);

    // random mix
    for (int n = 0; n < 20; n++) begin
      logic [3:0] len;
      int rb;
      int rl;
      len = 4'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
      rl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : int'(len);
      if ($urandom_range(0, 7) == 0) reset_and_check();
      do_burst(12'($urandom) & 12'hFFC, len, 16'($urandom), 32'($urandom),
               rb, rl, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_master.md
Name: axi_rd_master

Overview:
AXI3 read initiator. Turns single-command requests into INCR read bursts on AR/R and streams returned beats to a client port. It is the counterpart of the AXI3 dummy slave and drives its AR/R channels in bring-up and emulation. One burst is outstanding at a time, and the block checks the R channel for protocol errors.

Parameters:
aw, 12, address width
dw, 32, data width (power of 2, >=8)
idw, 16, ID width
TO_CYCLES, 256, timeout limit in cycles (used only with the optional feature)

Ports:
aclk  in  1  clock
areset  in  1  synchronous, active-high reset
cmd_valid  in  1  read command valid
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_addr  in  aw  start byte address
cmd_len  in  4  beats minus 1 (AXI3 arlen)
cmd_id  in  idw  transaction ID
rd_valid  out  1  client read beat valid
rd_ready  in  1  client beat accept
rd_data  out  dw  beat data
rd_last  out  1  final beat of burst
rd_resp  out  2  rresp of beat
prot_err  out  1  sticky: rid mismatch or rlast misplaced
busy  out  1  burst in progress
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
araddr  out  aw  AXI AR address
arburst  out  2  constant 2'b01 (INCR)
arsize  out  3  constant log2(dw/8)
arlen  out  4  AXI AR length
arid  out  idw  AXI AR ID
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
rid  in  idw  AXI R ID
rdata  in  dw  AXI R data
rresp  in  2  AXI R response
rlast  in  1  AXI R last

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- Reset, and the cycle after it:
  - State is IDLE.
  - arvalid, rready, rd_valid, rd_last, busy and prot_err are 0.
  - araddr, arlen, arid, rd_data and rd_resp are 0.
  - cmd_ready is 1.
  - Reset mid-burst drops the burst immediately with no drain.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid the block registers addr/len/id, loads beat_cnt = 0 and moves to ADDR.
  - The next cycle has arvalid = 1 and busy = 1, so command-to-arvalid latency is 1 cycle.
- ADDR:
  - arvalid is held with stable araddr/arlen/arid until arready is sampled high.
  - The handshake cycle moves the FSM to DATA.
  - arready high in the first arvalid cycle is legal.
- DATA:
  - rready = rd_ready, combinational pass-through. rd_valid = rvalid, rd_data = rdata, rd_resp = rresp.
  - rd_last = 1 when beat_cnt == len_q. This is the counted last, not rlast.
  - Each cycle with rvalid && rready increments beat_cnt by 1 (4-bit, no wrap: maximum is 15).
  - The beat with beat_cnt == len_q returns the FSM to IDLE. cmd_ready goes high the next cycle, so there is no same-cycle command overlap.
- Protocol checks (DATA state, on each R handshake): prot_err is set and held until reset when any of these occur:
  - rid != id_q
  - rlast == 1 while beat_cnt < len_q
  - rlast == 0 while beat_cnt == len_q
- rvalid outside DATA is ignored; rready is 0 there.
- rresp SLVERR/DECERR is forwarded on rd_resp only and does not set prot_err.
- araddr carries cmd_addr unmodified; the client guarantees alignment and no 4KB crossing.

Optional Feature:
AXI_RD_MASTER_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to ADDR and on every R handshake, and increments each cycle in ADDR/DATA without a handshake.
  - When the count reaches TO_CYCLES, output timeout_err (1-bit, sticky until reset, reset value 0) goes high and the FSM forces IDLE.
- Undefined: no counter, no timeout_err port, and the block waits indefinitely.

Test Plan:
1. Single read: cmd addr=0x100, len=0, id=0x5; slave returns rdata=0xDEADBEEF, rlast=1 -> arvalid the cycle after the command; araddr=0x100, arlen=0, arsize=2, arburst=1; one rd_valid beat with rd_last=1; back to IDLE; prot_err=0.
2. 16-beat burst (len=15) with rd_ready toggled 1/0 each cycle and arready delayed 3 cycles -> araddr/arlen stable throughout the wait; 16 beats delivered in order; rready mirrors rd_ready; rd_last only on beat 16.
3. Burst len=3 with rlast asserted on beat 2 -> prot_err=1 and stays 1 through the next clean command.
4. rid=0x6 returned for cmd_id=0x5 -> prot_err=1; data still forwarded.
5. Reset asserted during DATA beat 2 of 8 -> next cycle all outputs at reset values and cmd_ready=1; a new command then completes normally.
6. (macro on, TO_CYCLES=8) arready held 0 -> timeout_err=1 after 8 cycles; FSM in IDLE; cmd_ready=1.
